fifo_arbiter: RTL
=================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter data_width, default 10, word width of every FIFO data path.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port empty_in  input  4  empty flag of each upstream FIFO, bit i = lane i.
REQ-005 Port data_in0..data_in3  input  data_width each  read data of upstream FIFO lane 0..3.
REQ-006 Port almost_full_out  input  1  downstream FIFO almost-full back-pressure.
REQ-007 Port pop  output  4  registered one-hot pop request to upstream lanes.
REQ-008 Port push_out  output  1  registered push to downstream FIFO.
REQ-009 Port data_out  output  data_width  registered word for downstream FIFO.
REQ-010 Port grant_lane  output  2  index of the lane of the most recent pop.
REQ-011 Port idle  output  1  high when the FSM is in IDLE and no transfer is in flight.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ISSUE, WAIT.
REQ-013 IDLE->ISSUE when any empty_in bit is 0 and almost_full_out is 0; otherwise it stays in IDLE.
REQ-014 In ISSUE the arbiter SHALL pick one non-empty lane, register pop with only that bit set for one cycle, update grant_lane, and go to WAIT.
REQ-015 In WAIT pop SHALL be 0000; the next state is ISSUE if the IDLE->ISSUE condition holds, else IDLE.
REQ-016 Each lane SHALL therefore be popped at most once per two cycles, covering the one-cycle lag of the upstream empty flag.
REQ-017 Read latency: if pop[i] is high in cycle N, data_in<i> SHALL be sampled at the end of cycle N+1, and push_out=1 with data_out=that word in cycle N+2.
REQ-018 push_out SHALL be a single-cycle pulse per pop; push count equals pop count exactly.
REQ-019 Round-robin: search starts at lane (last grant + 1) mod 4 and wraps 3->0; the first non-empty lane wins.
REQ-020 After reset the last grant SHALL be treated as lane 3, so lane 0 has first priority.
REQ-021 almost_full_out=1 SHALL block new ISSUE entries; an already issued pop SHALL still complete its push.
REQ-022 A lane whose empty_in rises in the same cycle as ISSUE SHALL NOT be granted; the sampled empty_in value decides.
REQ-023 data_out SHALL hold its last value when push_out=0.
REQ-024 idle=1 only in IDLE with no push pending in the next two cycles.

Reset
REQ-025 With reset=1 at a rising edge, the FSM SHALL go to IDLE, with pop=0000, push_out=0, data_out=0, grant_lane=3, and idle=1.
REQ-026 A reset during ISSUE or WAIT SHALL cancel any in-flight push; the pipeline SHALL be flushed and no push_out appears after reset.
REQ-027 Reset SHALL override every other input in the same cycle.

Configuration
REQ-028 Macro FIFO_ARB_STRICT_PRIO_EN: when defined, REQ-019 SHALL be replaced by fixed priority, lowest-index non-empty lane wins and grant history is ignored.
REQ-029 Without FIFO_ARB_STRICT_PRIO_EN, round-robin per REQ-019 and REQ-020 SHALL apply; all other behaviour is identical in both builds.

Verification
REQ-030 Reset, then empty_in=1110, data_in0=0x2A5 -> pop=0001 in cycle 1, push_out=1 with data_out=0x2A5 in cycle 3, grant_lane=0.
REQ-031 All lanes non-empty continuously (round-robin build) -> pop sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-032 Same stimulus with FIFO_ARB_STRICT_PRIO_EN -> pop alternates 0001,0000 only; lanes 1-3 are never granted.
REQ-033 almost_full_out rises in the cycle after an ISSUE -> exactly one push_out occurs, then no pop until almost_full_out=0.
REQ-034 Reset asserted in the WAIT cycle after pop=0100 -> no push_out, outputs at reset values, idle=1 next cycle.
REQ-035 empty_in=0111 with lane 3 granted last -> the search wraps to lane 3 again and pop=1000 is issued every other cycle.

Source files
------------

// File: rtl/fifo_arbiter.sv
// Four-lane merge from upstream FIFOs into one downstream FIFO, one pop every two cycles.
// Define FIFO_ARB_STRICT_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module fifo_arbiter #(
   parameter int unsigned data_width = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            empty_in,
   input  logic [data_width-1:0] data_in0,
   input  logic [data_width-1:0] data_in1,
   input  logic [data_width-1:0] data_in2,
   input  logic [data_width-1:0] data_in3,
   input  logic                  almost_full_out,
   output logic [3:0]            pop,
   output logic                  push_out,
   output logic [data_width-1:0] data_out,
   output logic [1:0]            grant_lane,
   output logic                  idle
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e                state_q;
   logic [3:0]            pop_q;
   logic [1:0]            grant_q;
   logic                  rd_valid_q;
   logic [1:0]            rd_lane_q;
   logic                  push_q;
   logic [data_width-1:0] data_q;

   logic [data_width-1:0] lane_data [4];
   logic                  go;
   logic [1:0]            pick;
   logic [1:0]            rr_idx;

   assign lane_data[0] = data_in0;
   assign lane_data[1] = data_in1;
   assign lane_data[2] = data_in2;
   assign lane_data[3] = data_in3;

   assign go = ~&empty_in & ~almost_full_out;

   // Descending scan so the highest-priority candidate is assigned last and wins.
   always_comb begin
      pick   = grant_q;
      rr_idx = grant_q;
`ifdef FIFO_ARB_STRICT_PRIO_EN
      for (int i = 3; i >= 0; i--) begin
         if (!empty_in[i]) begin
            pick = 2'(i);
         end
      end
`else
      for (int off = 4; off >= 1; off--) begin
         rr_idx = grant_q + 2'(off);
         if (!empty_in[rr_idx]) begin
            pick = rr_idx;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         pop_q      <= 4'b0000;
         grant_q    <= 2'd3;
         rd_valid_q <= 1'b0;
         rd_lane_q  <= 2'd0;
         push_q     <= 1'b0;
         data_q     <= '0;
      end else begin
         // Upstream data is valid the cycle after pop; capture it at the end of that cycle.
         rd_valid_q <= |pop_q;
         rd_lane_q  <= grant_q;
         push_q     <= rd_valid_q;
         if (rd_valid_q) begin
            data_q <= lane_data[rd_lane_q];
         end

         case (state_q)
            StIdle, StWait: begin
               if (go) begin
                  state_q <= StIssue;
                  pop_q   <= 4'b0001 << pick;
                  grant_q <= pick;
               end else begin
                  state_q <= StIdle;
                  pop_q   <= 4'b0000;
               end
            end
            StIssue: begin
               state_q <= StWait;
               pop_q   <= 4'b0000;
            end
            default: begin
               state_q <= StIdle;
               pop_q   <= 4'b0000;
            end
         endcase
      end
   end

   assign pop        = pop_q;
   assign push_out   = push_q;
   assign data_out   = data_q;
   assign grant_lane = grant_q;
   assign idle       = (state_q == StIdle) && (pop_q == 4'b0000) && !rd_valid_q;

endmodule
